// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode and controller state encodings.
package alu_seq_pkg;

  // Codes 0x0-0x9 are unchanged from the combinational ALU; ADC/ROTL/MUL use free codes.
  typedef enum logic [3:0] {
    ALU_SLB    = 4'h0,
    ALU_ADD    = 4'h1,
    ALU_SUB    = 4'h2,
    ALU_SHIFTL = 4'h3,
    ALU_SHIFTR = 4'h4,
    ALU_BNZ    = 4'h5,
    ALU_SLT    = 4'h6,
    ALU_XOR    = 4'h7,
    ALU_AND    = 4'h8,
    ALU_OR     = 4'h9,
    ALU_ADC    = 4'hA,
    ALU_ROTL   = 4'hB,
    ALU_MUL    = 4'hC
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: the first partial product is folded in at start,
// the remaining WIDTH-1 follow one per cycle; done pulses the cycle after the last step.
module mul_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-2:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-2:0]   step;

  // Shift-add sequencer with a one-hot step counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= {(2*WIDTH){1'b0}};
      mcand   <= {(2*WIDTH-1){1'b0}};
      mplier  <= {WIDTH{1'b0}};
      step    <= {(WIDTH-1){1'b0}};
    end else if (start) begin
      product <= b[0] ? {{WIDTH{1'b0}}, a} : {(2*WIDTH){1'b0}};
      mcand   <= {{(WIDTH-2){1'b0}}, a, 1'b0};
      mplier  <= {1'b0, b[WIDTH-1:1]};
      step    <= {{(WIDTH-2){1'b0}}, 1'b1};
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (busy) begin
      if (mplier[0]) begin
        product <= product + {1'b0, mcand};
      end
      mcand  <= {mcand[2*WIDTH-3:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      step   <= {step[WIDTH-3:0], 1'b0};
      if (step[WIDTH-2]) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops complete in one cycle, MUL runs iteratively;
// results and flags are registered and held until the consumer takes them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] read1,
  input  logic [WIDTH-1:0] read0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_result,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  alu_state_t         state;
  alu_op_t            op;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     sum_add;
  logic [WIDTH:0]     sum_adc;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   rot_amt;
  logic [2*WIDTH-1:0] rot_dbl;
  logic [WIDTH-1:0]   calc_result;
  logic               calc_branch;
  logic               calc_carry;

  assign op        = alu_op_t'(alu_op);
  assign accept    = (state == IDLE) && in_valid;
  assign mul_start = accept && (op == ALU_MUL);

  assign sum_add = {1'b0, read1} + {1'b0, read0};
  assign sum_adc = {1'b0, read1} + {1'b0, read0} + {{WIDTH{1'b0}}, carry};
  assign diff    = {1'b0, read1} - {1'b0, read0};
  assign rot_amt = read0 % W_LIM;
  assign rot_dbl = {read1, read1} << rot_amt;

  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (read1),
    .b       (read0),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath; MUL and unknown opcodes fall through to the NOP result.
  always_comb begin
    calc_result = {WIDTH{1'b0}};
    calc_branch = 1'b0;
    calc_carry  = carry;
    case (op)
      ALU_SLB:    calc_result = {read1[WIDTH-1:WIDTH/2], read0[WIDTH/2-1:0]};
      ALU_ADD:    begin calc_result = sum_add[WIDTH-1:0]; calc_carry = sum_add[WIDTH]; end
      ALU_SUB:    begin calc_result = diff[WIDTH-1:0];    calc_carry = diff[WIDTH];    end
      ALU_ADC:    begin calc_result = sum_adc[WIDTH-1:0]; calc_carry = sum_adc[WIDTH]; end
      ALU_SHIFTL: begin
        if (read0 >= W_LIM) calc_result = {WIDTH{1'b0}};
        else                calc_result = read1 << read0[SHW-1:0];
      end
      ALU_SHIFTR: begin
        if (read0 >= W_LIM) calc_result = {WIDTH{1'b0}};
        else                calc_result = read1 >> read0[SHW-1:0];
      end
      ALU_ROTL:   calc_result = rot_dbl[2*WIDTH-1:WIDTH];
      ALU_BNZ:    calc_branch = (read1 != {WIDTH{1'b0}});
      ALU_SLT:    calc_result = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
      ALU_XOR:    calc_result = read1 ^ read0;
      ALU_AND:    calc_result = read1 & read0;
      ALU_OR:     calc_result = read1 | read0;
      default:    calc_result = {WIDTH{1'b0}};
    endcase
  end

  // Controller FSM with registered handshake, result and flag outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      result        <= {WIDTH{1'b0}};
      branch_result <= 1'b0;
      carry         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (op == ALU_MUL) begin
              state <= EXEC;
            end else begin
              state         <= DONE;
              out_valid     <= 1'b1;
              result        <= calc_result;
              branch_result <= calc_branch;
              carry         <= calc_carry;
            end
          end
        end
        EXEC: begin
          if (mul_done && !mul_busy) begin
            state         <= DONE;
            out_valid     <= 1'b1;
            result        <= mul_product[WIDTH-1:0];
            branch_result <= 1'b0;
            carry         <= |mul_product[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
